// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory request interface.
// Word-organised local RAM; every request completes a fixed LATENCY cycles after capture.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_good,
  output logic        data_err,
  output logic        busy
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        cap_adr, cap_adr_next;
  logic [31:0]        cap_wdata, cap_wdata_next;
  logic               cap_read, cap_read_next;
  logic [31:0]        data_rdata_next;
  logic               data_good_next;
  logic               data_err_next;
  logic               busy_next;
  logic               ram_we;
  logic [29:0]        word;
  logic [IDX_W-1:0]   idx;
  logic               addr_err;
  logic [31:0]        ram [DEPTH_WORDS];

  // BASE_ADDR is word-aligned, so subtracting word indices equals (adr - base) >> 2.
  assign word     = cap_adr[31:2] - BASE_WORD;
  assign idx      = word[IDX_W-1:0];
  assign addr_err = (cap_adr[1:0] != 2'b00) || (cap_adr < BASE_ADDR) || (word >= DEPTH_W30);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_adr    <= '0;
      cap_wdata  <= '0;
      cap_read   <= 1'b0;
      data_rdata <= '0;
      data_good  <= 1'b0;
      data_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cap_adr    <= cap_adr_next;
      cap_wdata  <= cap_wdata_next;
      cap_read   <= cap_read_next;
      data_rdata <= data_rdata_next;
      data_good  <= data_good_next;
      data_err   <= data_err_next;
      busy       <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (data_read || data_write) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next        = cnt;
    cap_adr_next    = cap_adr;
    cap_wdata_next  = cap_wdata;
    cap_read_next   = cap_read;
    data_rdata_next = data_rdata;
    data_good_next  = 1'b0;
    data_err_next   = 1'b0;
    ram_we          = 1'b0;
    case (state)
      IDLE: begin
        if (data_read || data_write) begin
          cap_adr_next   = data_adr;
          cap_wdata_next = data_wdata;
          cap_read_next  = data_read;
          cnt_next       = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          data_good_next = 1'b1;
          data_err_next  = addr_err;
          if (cap_read) data_rdata_next = addr_err ? 32'h0 : ram[idx];
          else          ram_we          = !addr_err;
        end
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Gating on rst drops a write whose completion edge coincides with reset assertion.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[idx] <= cap_wdata;
  end

endmodule
